// File: rtl/gol_pkg.sv
// Shared constants for the Game of Life generation counter: BCD digit limit,
// rate_sel encodings and the default per-generation clock divider.
package gol_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [1:0] RATE_X1 = 2'd0;
    localparam logic [1:0] RATE_X2 = 2'd1;
    localparam logic [1:0] RATE_X4 = 2'd2;
    localparam logic [1:0] RATE_X8 = 2'd3;

    localparam int unsigned DEFAULT_TICK_DIV = 100_000_000;

endpackage

// File: rtl/generation_counter_bcd_digit.sv
// One decimal digit of the generation count: increments on carry-in, rolls
// 9 -> 0 and raises a combinational carry-out so a full ripple settles in one cycle.
module bcd_digit
    import gol_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    assign cout = cin && (q == BCD_MAX);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= 4'd0;
        end else if (cin) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/generation_counter.sv
// Multi-digit BCD generation counter with programmable step rate, run/pause,
// single-step, clear, a per-generation tick and an all-nines wrap pulse.
module generation_counter
    import gol_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESC_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  step,
    input  logic                  clear,
    input  logic [1:0]            rate_sel,
    output logic                  tick,
    output logic                  wrap,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam logic [PRESC_W-1:0] DIV = PRESC_W'(TICK_DIV);
    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] term;
    logic               step_q;
    logic               step_rise;
    logic               at_term;
    logic               advance;
    logic [DIGITS:0]    carry;

    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    always_comb begin
        term = DIV - ONE;
        case (rate_sel)
            RATE_X1: term = DIV - ONE;
            RATE_X2: term = (DIV >> 1) - ONE;
            RATE_X4: term = (DIV >> 2) - ONE;
            RATE_X8: term = (DIV >> 3) - ONE;
            default: term = DIV - ONE;
        endcase
    end

    // >= rather than == so a shorter period selected mid-count fires at once.
    assign at_term   = (presc >= term);
    assign step_rise = step && !step_q;
    assign advance   = run ? at_term : step_rise;

    always_ff @(posedge clk) begin
        if (rst || clear || !run || at_term) begin
            presc <= '0;
        end else begin
            presc <= presc + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= advance;
            wrap <= carry[DIGITS];
        end
    end

    assign carry[0] = advance;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk  (clk),
            .rst  (rst),
            .clr  (clear),
            .cin  (carry[i]),
            .q    (bcd[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: tb/tb_generation_counter.sv
// Bench for generation_counter (TICK_DIV=8, DIGITS=2): directed scenarios plus
// random traffic, checked each cycle against an integer-count reference model.
module tb_generation_counter;

    localparam int TDIV   = 8;
    localparam int NDIG   = 2;
    localparam int PW     = 4;
    localparam int MODULO = 100;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           step;
    logic           clear;
    logic [1:0]     rate_sel;
    logic           tick;
    logic           wrap;
    logic [4*NDIG-1:0] bcd;

    int vectors    = 0;
    int miscompares = 0;

    generation_counter #(
        .TICK_DIV (TDIV),
        .DIGITS   (NDIG),
        .PRESC_W  (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step     (step),
        .clear    (clear),
        .rate_sel (rate_sel),
        .tick     (tick),
        .wrap     (wrap),
        .bcd      (bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: count as an integer, elapsed cycles within the current period.
    int   m_cnt;
    int   m_elapsed;
    int   m_period;
    bit   m_tick;
    bit   m_wrap;
    bit   m_step_q;
    bit   m_adv;
    bit   m_valid = 1'b0;
    logic [7:0] m_bcd;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0; m_elapsed = 0; m_tick = 0; m_wrap = 0; m_step_q = 0;
                m_valid = 1'b1;
            end else if (clear) begin
                m_cnt = 0; m_elapsed = 0; m_tick = 0; m_wrap = 0;
                m_step_q = step;
            end else begin
                m_period = TDIV >> rate_sel;
                if (run) m_adv = (m_elapsed >= m_period - 1);
                else     m_adv = step && !m_step_q;
                if (run && !m_adv) m_elapsed = m_elapsed + 1;
                else               m_elapsed = 0;
                m_tick = m_adv;
                m_wrap = m_adv && (m_cnt == MODULO - 1);
                if (m_adv) m_cnt = (m_cnt + 1) % MODULO;
                m_step_q = step;
            end
            #1;
            if (m_valid) begin
                m_bcd = {4'(m_cnt / 10), 4'(m_cnt % 10)};
                check("tick", 32'(tick), 32'(m_tick));
                check("wrap", 32'(wrap), 32'(m_wrap));
                check("bcd",  32'(bcd),  32'(m_bcd));
            end
        end
    end

    int ticks;
    int wraps;

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; clear = 1'b0; rate_sel = 2'd0;
        cycles(2);
        check("reset_bcd",  32'(bcd),  32'h0);
        check("reset_tick", 32'(tick), 32'h0);

        // Free run at x1: first tick 8 edges after release, then every 8.
        rst = 1'b0; run = 1'b1;
        cycles(7);
        check("x1_no_early_tick", 32'(tick), 32'h0);
        cycles(1);
        check("x1_first_tick", 32'(tick), 32'h1);
        check("x1_first_bcd",  32'(bcd),  32'h01);
        cycles(1);
        check("x1_tick_one_cycle", 32'(tick), 32'h0);
        cycles(7);
        check("x1_second_tick", 32'(tick), 32'h1);
        check("x1_second_bcd",  32'(bcd),  32'h02);

        // x8 at TICK_DIV=8: an advance every edge, one wrap per 100.
        rate_sel = 2'd3;
        ticks = 0; wraps = 0;
        for (int i = 0; i < 200; i++) begin
            cycles(1);
            ticks += int'(tick);
            wraps += int'(wrap);
            if (wrap) check("wrap_with_tick", 32'(tick), 32'h1);
        end
        check("x8_ticks", 32'(ticks), 32'd200);
        check("x8_wraps", 32'(wraps), 32'd2);

        // Single-step while paused.
        run = 1'b0; rate_sel = 2'd0; clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1; cycles(5);
            step = 1'b0; cycles(5);
        end
        check("step_bcd", 32'(bcd), 32'h03);
        step = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            ticks += int'(tick);
        end
        check("step_hold_ticks", 32'(ticks), 32'd1);
        check("step_hold_bcd",   32'(bcd),   32'h04);
        step = 1'b0;
        cycles(2);
        run = 1'b1; step = 1'b1;
        cycles(3);
        step = 1'b0;
        cycles(3);
        check("step_ignored_bcd",  32'(bcd),  32'h04);
        check("step_ignored_tick", 32'(tick), 32'h0);

        // Rate change mid-period: prescaler at 6, switch to x4.
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        cycles(6);
        rate_sel = 2'd2;
        cycles(1);
        check("rate_switch_tick", 32'(tick), 32'h1);
        check("rate_switch_bcd",  32'(bcd),  32'h01);
        cycles(1);
        check("rate_x4_gap", 32'(tick), 32'h0);
        cycles(1);
        check("rate_x4_tick", 32'(tick), 32'h1);
        check("rate_x4_bcd",  32'(bcd),  32'h02);

        // Clear coinciding with a terminal prescaler value at bcd=47.
        rate_sel = 2'd3; clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        cycles(47);
        check("reach_47", 32'(bcd), 32'h47);
        rate_sel = 2'd0;
        cycles(7);
        check("hold_47", 32'(bcd), 32'h47);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("clear_bcd",  32'(bcd),  32'h00);
        check("clear_tick", 32'(tick), 32'h0);
        cycles(7);
        check("clear_no_early_tick", 32'(tick), 32'h0);
        cycles(1);
        check("clear_next_tick", 32'(tick), 32'h1);
        check("clear_next_bcd",  32'(bcd),  32'h01);

        // Reset mid-period at bcd=19.
        rate_sel = 2'd3; clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        cycles(19);
        check("reach_19", 32'(bcd), 32'h19);
        rate_sel = 2'd0;
        cycles(3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midrst_bcd",  32'(bcd),  32'h00);
        check("midrst_tick", 32'(tick), 32'h0);
        check("midrst_wrap", 32'(wrap), 32'h0);
        cycles(7);
        check("midrst_no_early_tick", 32'(tick), 32'h0);
        cycles(1);
        check("midrst_tick_after", 32'(tick), 32'h1);
        check("midrst_bcd_after",  32'(bcd),  32'h01);

        // Random traffic; the model process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            cycles(1);
            rst   = ($urandom_range(0, 299) == 0);
            clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 3) == 0)  step = ~step;
            if ($urandom_range(0, 59) == 0) rate_sel = 2'($urandom_range(0, 3));
        end
        rst = 1'b0; clear = 1'b0;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
